// File: rtl/gaussian_col_conv_stream.sv
// Streaming 5-tap vertical Gaussian filter: 4 circular line buffers, 2-stage pipeline, edge-row replication.
// Latency 2 cycles per pixel; pipeline freezes when out_valid && !out_ready. Option macro: GCOL_ROUND_EN.
module gaussian_col_conv_stream #(
  parameter int          WIDTH  = 128,
  parameter int          HEIGHT = 128,
  parameter int          DATA_W = 8,
  parameter logic [7:0]  W0     = 8'd1,
  parameter logic [7:0]  W1     = 8'd4,
  parameter logic [7:0]  W2     = 8'd6,
  parameter logic [7:0]  W3     = 8'd4,
  parameter logic [7:0]  W4     = 8'd1,
  parameter int          SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done
);

  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW    = $clog2(HEIGHT);
  localparam int SUM_W = DATA_W + 11;
  localparam logic [DATA_W-1:0] PIX_MAX = {DATA_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_lb [4][WIDTH];

  logic              r_s1_vld, r_s1_last;
  logic [DATA_W-1:0] r_s1_tap [5];
  logic [DATA_W-1:0] w_tap [5];

  logic [DATA_W-1:0] r_out_dat;
  logic              r_out_vld, r_out_last, r_done;

  logic              w_advance, w_acc, w_fl_issue, w_issue, w_step;
  logic              w_col_end, w_row_last;
  logic [SUM_W-1:0]  w_sum, w_res;
  logic [DATA_W-1:0] w_dat;
  int                w_base, w_trow;

  assign w_advance  = !r_out_vld || out_ready;
  assign in_ready   = w_advance && (r_state == S_PRIME || r_state == S_RUN);
  assign w_acc      = in_valid && in_ready;
  assign w_fl_issue = w_advance && (r_state == S_FLUSH);
  assign w_issue    = (w_acc && r_state == S_RUN) || w_fl_issue;
  assign w_step     = w_acc || w_fl_issue;
  assign w_col_end  = (r_col == CW'(WIDTH - 1));
  assign w_row_last = (r_row == RW'(HEIGHT - 1));

  assign out_data  = r_out_dat;
  assign out_valid = r_out_vld;
  assign out_last  = r_out_last;
  assign done      = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_PRIME;
      S_PRIME: if (w_acc && w_col_end && r_row == RW'(1)) w_state_nxt = S_RUN;
      S_RUN:   if (w_acc && w_col_end && w_row_last) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_fl_issue && w_col_end && w_row_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_out_vld && out_ready && r_out_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // In PRIME/RUN the counters track the input row; in FLUSH they track the output row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_step) begin
      if (w_col_end) begin
        r_col <= '0;
        if (r_state == S_RUN && w_row_last)        r_row <= RW'(HEIGHT - 2);
        else if (r_state == S_FLUSH && w_row_last) r_row <= '0;
        else                                       r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_lb[r_row[1:0]][r_col] <= in_data;
  end

  // Tap rows are clamped to the frame so edge rows replicate; in RUN the newest row is the live input.
  always_comb begin
    w_base = (r_state == S_RUN) ? int'(r_row) - 2 : int'(r_row);
    w_trow = 0;
    for (int i = 0; i < 5; i++) begin
      w_trow = w_base + i - 2;
      if (w_trow < 0) w_trow = 0;
      if (w_trow > HEIGHT - 1) w_trow = HEIGHT - 1;
      w_tap[i] = r_lb[w_trow[1:0]][r_col];
    end
    if (r_state == S_RUN) w_tap[4] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
    end else if (w_advance) begin
      r_s1_vld <= w_issue;
      if (w_issue) r_s1_last <= (r_state == S_FLUSH) && w_col_end && w_row_last;
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance && w_issue) begin
      for (int i = 0; i < 5; i++) r_s1_tap[i] <= w_tap[i];
    end
  end

  always_comb begin
    w_sum = SUM_W'(r_s1_tap[0]) * SUM_W'(W0) + SUM_W'(r_s1_tap[1]) * SUM_W'(W1)
          + SUM_W'(r_s1_tap[2]) * SUM_W'(W2) + SUM_W'(r_s1_tap[3]) * SUM_W'(W3)
          + SUM_W'(r_s1_tap[4]) * SUM_W'(W4);
`ifdef GCOL_ROUND_EN
    w_res = (w_sum + (SUM_W'(1) << (SHIFT - 1))) >> SHIFT;
`else
    w_res = w_sum >> SHIFT;
`endif
    w_dat = (w_res > SUM_W'(PIX_MAX)) ? PIX_MAX : w_res[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_dat  <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= r_out_vld && out_ready && r_out_last;
      if (w_advance) begin
        r_out_vld  <= r_s1_vld;
        r_out_last <= r_s1_vld && r_s1_last;
        if (r_s1_vld) r_out_dat <= w_dat;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_col_conv_stream.sv
// Directed bench for gaussian_col_conv_stream on an 8x8 frame, plus a 4x3 instance for saturation.
module tb_gaussian_col_conv_stream;

  localparam int TW = 8;
  localparam int TH = 8;
  localparam int N  = TW * TH;
`ifdef GCOL_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic [7:0] in_data, out_data;

  logic       s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_done;
  logic [7:0] s_in_data, s_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] img     [N];
  logic [7:0] got     [N];
  logic [7:0] exp_img [N];

  always #5 clk = ~clk;

  gaussian_col_conv_stream #(.WIDTH(TW), .HEIGHT(TH), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done)
  );

  gaussian_col_conv_stream #(.WIDTH(4), .HEIGHT(3), .DATA_W(8), .W2(8'd32)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_last(s_out_last), .done(s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) begin
      img[i]     = 8'(v);
      exp_img[i] = 8'(v);
    end
  endtask

  task automatic compare_frame(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s[r%0d,c%0d]", tag, i / TW, i % TW), 32'(got[i]), 32'(exp_img[i]));
  endtask

  // Drives img[] in raster order and records accepted output beats into got[].
  task automatic run_frame(input bit bp, input int start_at, input int abort_at);
    int         ip, op, cyc, last_cyc, done_cyc, stall_bad, last_bad;
    bit         pend, prev_stall, aborted;
    logic [7:0] prev_dat;
    ip = 0; op = 0; cyc = 0; last_cyc = -5; done_cyc = -1; stall_bad = 0; last_bad = 0;
    pend = 1'b0; prev_stall = 1'b0; aborted = 1'b0; prev_dat = '0;
    for (int i = 0; i < N; i++) got[i] = 'x;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge clk);
      start = (cyc == start_at);
      if (abort_at >= 0 && ip == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid_async", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("rst_mid_out_valid", 32'(out_valid), 0);
        check("rst_mid_in_ready", 32'(in_ready), 0);
        check("rst_mid_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (!pend) begin
        in_valid = (ip < N) && (!bp || $urandom_range(0, 9) < 7);
        in_data  = (ip < N) ? img[ip] : 8'd0;
      end
      out_ready = !bp || ($urandom_range(0, 1) == 1);
      #1;
      if (done) done_cyc = cyc;
      if (prev_stall && out_data !== prev_dat) stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      if (out_valid && out_ready) begin
        if (op < N) got[op] = out_data;
        if (out_last !== (op == N - 1)) last_bad++;
        if (out_last) last_cyc = cyc;
        op++;
      end
      if (in_valid && in_ready) begin
        ip++;
        pend = 1'b0;
      end else begin
        pend = in_valid;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    if (!aborted) begin
      check("done_seen", 32'(done_cyc >= 0), 1);
      check("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
      check("beat_count", 32'(op), 32'(N));
      check("inputs_taken", 32'(ip), 32'(N));
      check("out_last_position", 32'(last_bad), 0);
      check("stall_data_stable", 32'(stall_bad), 0);
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      check("idle_in_ready", 32'(in_ready), 0);
      check("done_single_pulse", 32'(done), 0);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int beats, bad, lastpos, sdone, sip;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'd7; out_ready = 1'b1;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 8'd0; s_out_ready = 1'b1;
    #1;
    check("reset_out_data", 32'(out_data), 0);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_last", 32'(out_last), 0);
    check("reset_done", 32'(done), 0);
    check("reset_in_ready", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_no_start_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;

    fill(100);
    run_frame(1'b0, -1, -1);
    compare_frame("flat100");

    // Impulse 160 at (5,3); also a stray start mid-frame that must be ignored.
    fill(0);
    img[5*TW+3] = 8'd160;
    exp_img[3*TW+3] = 8'd10; exp_img[4*TW+3] = 8'd40; exp_img[5*TW+3] = 8'd60;
    exp_img[6*TW+3] = 8'd40; exp_img[7*TW+3] = 8'd10;
    run_frame(1'b0, 30, -1);
    compare_frame("impulse");

    run_frame(1'b1, -1, -1);
    compare_frame("impulse_bp");

    fill(0);
    for (int c = 0; c < TW; c++) begin
      img[c] = 8'd16;
      exp_img[c] = 8'd11; exp_img[TW+c] = 8'd5; exp_img[2*TW+c] = 8'd1;
    end
    run_frame(1'b0, -1, -1);
    compare_frame("top_border");

    fill(0);
    for (int c = 0; c < TW; c++) begin
      img[7*TW+c] = 8'd16;
      exp_img[7*TW+c] = 8'd11; exp_img[6*TW+c] = 8'd5; exp_img[5*TW+c] = 8'd1;
    end
    run_frame(1'b0, -1, -1);
    compare_frame("bottom_border");

    fill(0);
    img[5*TW+3] = 8'd8;
    run_frame(1'b0, -1, -1);
    check("round_r3c3", 32'(got[3*TW+3]), 32'(RND));
    check("round_r4c3", 32'(got[4*TW+3]), 2);
    check("round_r5c3", 32'(got[5*TW+3]), 3);
    check("round_r7c3", 32'(got[7*TW+3]), 32'(RND));
    check("round_r5c2", 32'(got[5*TW+2]), 0);

    fill(100);
    run_frame(1'b0, -1, 40);
    fill(50);
    run_frame(1'b0, -1, -1);
    compare_frame("flat50_after_reset");

    // Saturating instance: 4x3 frame of 255 with centre weight 32.
    beats = 0; bad = 0; lastpos = -1; sdone = 0; sip = 0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0; s_in_valid = 1'b1; s_in_data = 8'd255;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_out_valid) begin
        if (s_out_data !== 8'd255) bad++;
        if (s_out_last) lastpos = beats;
        beats++;
      end
      if (s_done) sdone++;
      if (s_in_valid && s_in_ready) sip++;
      if (sip == 12) s_in_valid = 1'b0;
    end
    check("sat_beats", 32'(beats), 12);
    check("sat_values_255", 32'(bad), 0);
    check("sat_last_pos", 32'(lastpos), 11);
    check("sat_done_pulses", 32'(sdone), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
